sum_operand_loader: RTL

- Front-end and back-end for the N-input / K-cycle summing core.
- Accepts W-bit operands one at a time over a valid/ready stream and buffers N of them.
- Presents all N operands in parallel to the core and pulses a start, then captures the core's result after exactly K cycles.
- Returns the result over a valid/ready output stream, with a mismatch flag against a locally accumulated reference sum.

---
 rtl/sum_operand_loader.sv | 84 ++++++++
 1 files changed

// File: rtl/sum_operand_loader.sv
// rtl/sum_operand_loader.sv - operand buffer, start/capture sequencer and result stream for the N-input summing core
module sum_operand_loader #(
  parameter int N  = 20,
  parameter int W  = 5,
  parameter int K  = 5,
  parameter int RW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [W-1:0]    in_data,
  output logic            in_ready,
  output logic [N*W-1:0]  num_flat,
  output logic            sum_start,
  input  logic [RW-1:0]   sum_result,
  output logic            res_valid,
  output logic [RW-1:0]   res_data,
  output logic            res_err,
  input  logic            res_ready
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {FILL, RUN, OUT} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   acc;

  assign in_ready = (state == FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      cnt       <= '0;
      acc       <= '0;
      num_flat  <= '0;
      sum_start <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            num_flat[int'(idx)*W +: W] <= in_data;
            acc <= acc + RW'(in_data);
            if (idx == IW'(N-1)) begin
              idx       <= '0;
              cnt       <= '0;
              sum_start <= 1'b1;
              state     <= RUN;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        RUN: begin
          // cnt==K-1 marks the edge on which the core's result is valid
          sum_start <= 1'b0;
          cnt       <= cnt + 1'b1;
          if (cnt == CW'(K-1)) begin
            res_data  <= sum_result;
            res_err   <= (sum_result != acc);
            res_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            acc       <= '0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
